// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown timer with load / start / pause control.
//
// Ports
//   clk                  system clock, rising-edge active
//   reset                asynchronous active-high reset
//   tick                 one-cycle pulse per second, decrement enable
//   load                 one-cycle pulse, load preset digits (validated)
//   load_min_tens..      BCD preset digits
//   start                begin or resume counting
//   pause                suspend counting
//   min_tens..sec_ones   registered remaining time, BCD
//   sec_borrow           pulse when seconds wrap 00->59
//   running              high while counting
//   expired              high while the timer sits at 00:00 after counting down
//   alarm                pulse on reaching 00:00
//   load_err             pulse when a load is rejected
module countdown_timer #(
   parameter int unsigned MIN_MAX = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic [3:0] load_min_tens,
   input  logic [3:0] load_min_ones,
   input  logic [3:0] load_sec_tens,
   input  logic [3:0] load_sec_ones,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       sec_borrow,
   output logic       running,
   output logic       expired,
   output logic       alarm,
   output logic       load_err
);

   localparam int unsigned DW = 4;
   localparam int unsigned MW = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_PAUSED  = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] min_tens_q, min_tens_d;
   logic [DW-1:0] min_ones_q, min_ones_d;
   logic [DW-1:0] sec_tens_q, sec_tens_d;
   logic [DW-1:0] sec_ones_q, sec_ones_d;
   logic          sec_borrow_q, sec_borrow_d;
   logic          running_q, running_d;
   logic          expired_q, expired_d;
   logic          alarm_q, alarm_d;
   logic          load_err_q, load_err_d;

   logic [MW-1:0] load_min_val;
   logic          load_ok;
   logic          time_zero;
   logic          last_second;

   // Preset validation: minutes value is range-checked as a binary number.
   always_comb begin
      load_min_val = MW'(load_min_tens) * MW'(10) + MW'(load_min_ones);
      load_ok      = (load_sec_tens <= DW'(5)) && (load_sec_ones <= DW'(9)) &&
                     (load_min_ones <= DW'(9)) && (32'(load_min_val) <= MIN_MAX);
   end

   always_comb begin
      time_zero   = (min_tens_q == '0) && (min_ones_q == '0) &&
                    (sec_tens_q == '0) && (sec_ones_q == '0);
      // 00:01 is the only time from which a decrement lands on 00:00.
      last_second = (min_tens_q == '0) && (min_ones_q == '0) &&
                    (sec_tens_q == '0) && (sec_ones_q == DW'(1));
   end

   // Next-state and next-output logic; priority load > pause > start > tick.
   always_comb begin
      state_d      = state_q;
      min_tens_d   = min_tens_q;
      min_ones_d   = min_ones_q;
      sec_tens_d   = sec_tens_q;
      sec_ones_d   = sec_ones_q;
      sec_borrow_d = 1'b0;
      alarm_d      = 1'b0;
      load_err_d   = 1'b0;

      if (load) begin
         if (load_ok) begin
            min_tens_d = load_min_tens;
            min_ones_d = load_min_ones;
            sec_tens_d = load_sec_tens;
            sec_ones_d = load_sec_ones;
            state_d    = S_IDLE;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (pause) begin
         if (state_q == S_RUN) begin
            state_d = S_PAUSED;
         end
      end else if (start) begin
         if (((state_q == S_IDLE) || (state_q == S_PAUSED)) && !time_zero) begin
            state_d = S_RUN;
         end
      end else if (tick && (state_q == S_RUN)) begin
         if (sec_ones_q != '0) begin
            sec_ones_d = sec_ones_q - DW'(1);
         end else if (sec_tens_q != '0) begin
            sec_ones_d = DW'(9);
            sec_tens_d = sec_tens_q - DW'(1);
         end else begin
            // Seconds wrap 00->59 and borrow one minute; RUN never holds 00:00.
            sec_ones_d   = DW'(9);
            sec_tens_d   = DW'(5);
            sec_borrow_d = 1'b1;
            if (min_ones_q != '0) begin
               min_ones_d = min_ones_q - DW'(1);
            end else begin
               min_ones_d = DW'(9);
               min_tens_d = min_tens_q - DW'(1);
            end
         end
         if (last_second) begin
            state_d = S_EXPIRED;
            alarm_d = 1'b1;
         end
      end

      running_d = (state_d == S_RUN);
      expired_d = (state_d == S_EXPIRED);
   end

   // State, digit and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         min_tens_q   <= '0;
         min_ones_q   <= '0;
         sec_tens_q   <= '0;
         sec_ones_q   <= '0;
         sec_borrow_q <= 1'b0;
         running_q    <= 1'b0;
         expired_q    <= 1'b0;
         alarm_q      <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         min_tens_q   <= min_tens_d;
         min_ones_q   <= min_ones_d;
         sec_tens_q   <= sec_tens_d;
         sec_ones_q   <= sec_ones_d;
         sec_borrow_q <= sec_borrow_d;
         running_q    <= running_d;
         expired_q    <= expired_d;
         alarm_q      <= alarm_d;
         load_err_q   <= load_err_d;
      end
   end

   assign min_tens   = min_tens_q;
   assign min_ones   = min_ones_q;
   assign sec_tens   = sec_tens_q;
   assign sec_ones   = sec_ones_q;
   assign sec_borrow = sec_borrow_q;
   assign running    = running_q;
   assign expired    = expired_q;
   assign alarm      = alarm_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scenario-driven bench for countdown_timer.
// Each scenario queues stimulus vectors with their expected outputs; expectations
// enter the scoreboard when the vector is driven and are compared one edge later.
module tb_countdown_timer;

   typedef logic [20:0] obs_t;  // {mm:ss BCD, borrow, running, expired, alarm, load_err}

   typedef struct packed {
      logic        ld;
      logic        st;
      logic        pa;
      logic        tk;
      logic [15:0] lt;
   } stim_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick, load, start, pause;
   logic [3:0] load_min_tens, load_min_ones, load_sec_tens, load_sec_ones;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       sec_borrow, running, expired, alarm, load_err;

   int   n_cmp = 0;
   int   n_bad = 0;
   obs_t sb[$];
   stim_t plan_s[$];
   obs_t  plan_e[$];

   countdown_timer #(.MIN_MAX(59)) dut (
      .clk(clk), .reset(reset), .tick(tick), .load(load),
      .load_min_tens(load_min_tens), .load_min_ones(load_min_ones),
      .load_sec_tens(load_sec_tens), .load_sec_ones(load_sec_ones),
      .start(start), .pause(pause),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .sec_borrow(sec_borrow), .running(running), .expired(expired),
      .alarm(alarm), .load_err(load_err)
   );

   always #5 clk = ~clk;

   function automatic obs_t ev(input logic [15:0] t, input logic b, input logic r,
                               input logic e, input logic a, input logic le);
      return {t, b, r, e, a, le};
   endfunction

   function automatic obs_t obs();
      return {min_tens, min_ones, sec_tens, sec_ones, sec_borrow, running, expired, alarm, load_err};
   endfunction

   function automatic stim_t sv(input logic ld, input logic st, input logic pa,
                                input logic tk, input logic [15:0] lt);
      stim_t s;
      s = '{ld: ld, st: st, pa: pa, tk: tk, lt: lt};
      return s;
   endfunction

   task automatic add(input stim_t s, input obs_t e);
      plan_s.push_back(s);
      plan_e.push_back(e);
   endtask

   // Apply one vector for exactly one rising edge, then release the pulses.
   task automatic drive(input stim_t s);
      @(negedge clk);
      load  = s.ld;
      start = s.st;
      pause = s.pa;
      tick  = s.tk;
      {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = s.lt;
      @(posedge clk);
      #1;
      load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
   endtask

   task automatic test_reset();
      obs_t got, exp;
      reset = 1'b1;
      #1;
      sb.push_back(ev(16'h0000, 0, 0, 0, 0, 0));
      got = obs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL reset_state: got %h expected %h", got, exp);
      end
      @(negedge clk);
      reset = 1'b0;
      // First edge after release must act on inputs.
      sb.push_back(ev(16'h0007, 0, 0, 0, 0, 0));
      drive(sv(1, 0, 0, 0, 16'h0007));
      got = obs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL reset_first_edge: got %h expected %h", got, exp);
      end
   endtask

   task automatic test_basic_countdown();
      obs_t got, exp;
      add(sv(1, 0, 0, 0, 16'h0102), ev(16'h0102, 0, 0, 0, 0, 0));
      add(sv(0, 1, 0, 0, 16'h0000), ev(16'h0102, 0, 1, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0101, 0, 1, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0100, 0, 1, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0059, 1, 1, 0, 0, 0));
      add(sv(0, 0, 0, 0, 16'h0000), ev(16'h0059, 0, 1, 0, 0, 0));
      // Minute-tens borrow: 10:00 -> 09:59.
      add(sv(1, 0, 0, 0, 16'h1000), ev(16'h1000, 0, 0, 0, 0, 0));
      add(sv(0, 1, 0, 0, 16'h0000), ev(16'h1000, 0, 1, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0959, 1, 1, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0958, 0, 1, 0, 0, 0));
      while (plan_s.size() > 0) begin
         sb.push_back(plan_e.pop_front());
         drive(plan_s.pop_front());
         got = obs(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL basic_countdown: got %h expected %h", got, exp);
         end
      end
   endtask

   task automatic test_expire();
      obs_t got, exp;
      add(sv(1, 0, 0, 0, 16'h0002), ev(16'h0002, 0, 0, 0, 0, 0));
      add(sv(0, 1, 0, 0, 16'h0000), ev(16'h0002, 0, 1, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0001, 0, 1, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0000, 0, 0, 1, 1, 0));
      add(sv(0, 0, 0, 0, 16'h0000), ev(16'h0000, 0, 0, 1, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0000, 0, 0, 1, 0, 0));
      add(sv(0, 1, 0, 0, 16'h0000), ev(16'h0000, 0, 0, 1, 0, 0));
      add(sv(0, 0, 1, 1, 16'h0000), ev(16'h0000, 0, 0, 1, 0, 0));
      add(sv(1, 0, 0, 0, 16'h0130), ev(16'h0130, 0, 0, 0, 0, 0));
      while (plan_s.size() > 0) begin
         sb.push_back(plan_e.pop_front());
         drive(plan_s.pop_front());
         got = obs(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL expire: got %h expected %h", got, exp);
         end
      end
   endtask

   task automatic test_pause_resume();
      obs_t got, exp;
      add(sv(1, 0, 0, 0, 16'h0010), ev(16'h0010, 0, 0, 0, 0, 0));
      add(sv(0, 1, 0, 0, 16'h0000), ev(16'h0010, 0, 1, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0009, 0, 1, 0, 0, 0));
      add(sv(0, 0, 1, 1, 16'h0000), ev(16'h0009, 0, 0, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0009, 0, 0, 0, 0, 0));
      add(sv(0, 1, 0, 1, 16'h0000), ev(16'h0009, 0, 1, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0008, 0, 1, 0, 0, 0));
      add(sv(0, 1, 0, 1, 16'h0000), ev(16'h0008, 0, 1, 0, 0, 0));
      while (plan_s.size() > 0) begin
         sb.push_back(plan_e.pop_front());
         drive(plan_s.pop_front());
         got = obs(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL pause_resume: got %h expected %h", got, exp);
         end
      end
   endtask

   // Starts from RUN at 00:08 left by the previous scenario.
   task automatic test_load_err();
      obs_t got, exp;
      add(sv(1, 0, 0, 1, 16'h0160), ev(16'h0008, 0, 1, 0, 0, 1));
      add(sv(0, 0, 0, 0, 16'h0000), ev(16'h0008, 0, 1, 0, 0, 0));
      add(sv(1, 0, 0, 0, 16'h6000), ev(16'h0008, 0, 1, 0, 0, 1));
      add(sv(1, 0, 0, 0, 16'h0A00), ev(16'h0008, 0, 1, 0, 0, 1));
      add(sv(1, 0, 0, 0, 16'h000A), ev(16'h0008, 0, 1, 0, 0, 1));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0007, 0, 1, 0, 0, 0));
      add(sv(1, 0, 0, 0, 16'h5959), ev(16'h5959, 0, 0, 0, 0, 0));
      while (plan_s.size() > 0) begin
         sb.push_back(plan_e.pop_front());
         drive(plan_s.pop_front());
         got = obs(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL load_err: got %h expected %h", got, exp);
         end
      end
   endtask

   task automatic test_idle_start();
      obs_t got, exp;
      add(sv(1, 0, 0, 0, 16'h0000), ev(16'h0000, 0, 0, 0, 0, 0));
      add(sv(0, 1, 0, 0, 16'h0000), ev(16'h0000, 0, 0, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0000, 0, 0, 0, 0, 0));
      add(sv(1, 0, 0, 0, 16'h0005), ev(16'h0005, 0, 0, 0, 0, 0));
      add(sv(0, 1, 1, 0, 16'h0000), ev(16'h0005, 0, 0, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0005, 0, 0, 0, 0, 0));
      add(sv(0, 1, 0, 0, 16'h0000), ev(16'h0005, 0, 1, 0, 0, 0));
      add(sv(0, 0, 1, 0, 16'h0000), ev(16'h0005, 0, 0, 0, 0, 0));
      add(sv(0, 1, 0, 0, 16'h0000), ev(16'h0005, 0, 1, 0, 0, 0));
      add(sv(0, 0, 0, 1, 16'h0000), ev(16'h0004, 0, 1, 0, 0, 0));
      while (plan_s.size() > 0) begin
         sb.push_back(plan_e.pop_front());
         drive(plan_s.pop_front());
         got = obs(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL idle_start: got %h expected %h", got, exp);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      obs_t got, exp;
      add(sv(1, 0, 0, 0, 16'h0530), ev(16'h0530, 0, 0, 0, 0, 0));
      add(sv(0, 1, 0, 0, 16'h0000), ev(16'h0530, 0, 1, 0, 0, 0));
      while (plan_s.size() > 0) begin
         sb.push_back(plan_e.pop_front());
         drive(plan_s.pop_front());
         got = obs(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL reset_mid_run_setup: got %h expected %h", got, exp);
         end
      end
      // Assert between edges; the clear must be visible before the next edge.
      #2;
      tick = 1'b1;
      reset = 1'b1;
      sb.push_back(ev(16'h0000, 0, 0, 0, 0, 0));
      #1;
      got = obs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL reset_async_clear: got %h expected %h", got, exp);
      end
      @(negedge clk);
      reset = 1'b0;
      tick  = 1'b0;
      sb.push_back(ev(16'h0000, 0, 0, 0, 0, 0));
      drive(sv(0, 0, 0, 1, 16'h0000));
      got = obs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL reset_idle_after: got %h expected %h", got, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
      {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = 16'h0000;
      test_reset();
      test_basic_countdown();
      test_expire();
      test_pause_resume();
      test_load_err();
      test_idle_start();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
